// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes,
// FSM state encoding and the natural-alignment check.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } lsu_state_e;

    // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double
    function automatic logic lsu_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (addr_lo[0] == 1'b0);
            2'd2:    ok = (addr_lo[1:0] == 2'b00);
            2'd3:    ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: shifts the addressed lane down and
// sign/zero-extends it according to funct3.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
    input  logic [2:0]                      funct3_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    output logic [DATA_WIDTH-1:0]           result_o
);

    logic [DATA_WIDTH-1:0] lane_s;

    // Lane select and extension; word sign-extension is identity at 32 bits
    always_comb begin
        lane_s = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            LSU_B:   result_o = DATA_WIDTH'(signed'(lane_s[7:0]));
            LSU_H:   result_o = DATA_WIDTH'(signed'(lane_s[15:0]));
            LSU_W:   result_o = DATA_WIDTH'(signed'(lane_s[31:0]));
            LSU_D:   result_o = lane_s;
            LSU_BU:  result_o = DATA_WIDTH'(lane_s[7:0]);
            LSU_HU:  result_o = DATA_WIDTH'(lane_s[15:0]);
            LSU_WU:  result_o = DATA_WIDTH'(lane_s[31:0]);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: byte-enable and store-lane generation, load
// extraction, and a req/ack memory handshake with timeout and pipeline stall.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_stall_M,
    output logic [DATA_WIDTH-1:0] o_rdata_M,
    output logic                  o_done,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    load_store_unit_if.master     bus
);

    localparam int  NB   = DATA_WIDTH / 8;
    localparam int  OFFW = $clog2(NB);
    localparam int  CNTW = $clog2(TIMEOUT);
    localparam bit  IS64 = (DATA_WIDTH == 64);

    lsu_state_e            state_q;
    logic [CNTW-1:0]       cnt_q;
    logic [OFFW-1:0]       off_q;
    logic [2:0]            funct3_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [NB-1:0]         mem_be_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [1:0]            size_s;
    logic [OFFW-1:0]       off_s;
    logic                  illegal_s;
    logic                  misaligned_s;
    logic [NB-1:0]         be_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    // Request decode: legality, alignment, byte enables and replicated store data
    always_comb begin
        size_s       = i_funct3[1:0];
        off_s        = i_addr[OFFW-1:0];
        illegal_s    = (i_funct3 == 3'b111) ||
                       (!IS64 && ((i_funct3 == LSU_D) || (i_funct3 == LSU_WU)));
        misaligned_s = illegal_s || !lsu_aligned(size_s, i_addr[2:0]);
        case (size_s)
            2'd0: begin
                be_s    = NB'(1'b1) << off_s;
                wdata_s = {NB{i_wdata[7:0]}};
            end
            2'd1: begin
                be_s    = NB'(2'b11) << off_s;
                wdata_s = {(NB/2){i_wdata[15:0]}};
            end
            2'd2: begin
                be_s    = NB'(4'hF) << off_s;
                wdata_s = {(NB/4){i_wdata[31:0]}};
            end
            default: begin
                be_s    = '1;
                wdata_s = i_wdata;
            end
        endcase
    end

    load_store_unit_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .rdata_i  (bus.mem_rdata),
        .result_o (load_data_s)
    );

    // Access FSM; every bus and result output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            funct3_q     <= 3'b000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            o_rdata_M    <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (misaligned_s) begin
                            state_q      <= ST_FIN;
                            o_misaligned <= 1'b1;
                            o_rdata_M    <= '0;
                        end else begin
                            state_q     <= ST_REQ;
                            cnt_q       <= '0;
                            off_q       <= off_s;
                            funct3_q    <= i_funct3;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= i_we;
                            mem_addr_q  <= {i_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            mem_be_q    <= be_s;
                            mem_wdata_q <= wdata_s;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack arriving on the last allowed cycle still wins over the timeout
                    if (bus.mem_ack) begin
                        state_q   <= ST_FIN;
                        mem_req_q <= 1'b0;
                        o_done    <= 1'b1;
                        o_rdata_M <= mem_we_q ? '0 : load_data_s;
                    end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        state_q   <= ST_FIN;
                        mem_req_q <= 1'b0;
                        o_bus_err <= 1'b1;
                        o_rdata_M <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall_M     = i_req_valid && (state_q != ST_FIN);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one 32-bit and one 64-bit instance,
// each scenario task drives a bus model and compares against fixed values.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid32, req_valid64;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic        stall32, done32, mis32, err32;
    logic [31:0] rdata32;
    logic        stall64, done64, mis64, err64;
    logic [63:0] rdata64;

    int checks = 0;
    int errors = 0;

    load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
    load_store_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut32 (
        .clk(clk), .rst(rst), .i_req_valid(req_valid32), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata[31:0]), .o_stall_M(stall32), .o_rdata_M(rdata32),
        .o_done(done32), .o_misaligned(mis32), .o_bus_err(err32), .bus(bus32)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .i_req_valid(req_valid64), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_stall_M(stall64), .o_rdata_M(rdata64),
        .o_done(done64), .o_misaligned(mis64), .o_bus_err(err64), .bus(bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // View of whichever instance the current scenario targets
    logic        sel64;
    logic        cur_stall, cur_req, cur_done, cur_mis, cur_err, cur_we;
    logic [7:0]  cur_be;
    logic [31:0] cur_maddr;
    logic [63:0] cur_mwdata, cur_rdata;
    assign cur_stall  = sel64 ? stall64 : stall32;
    assign cur_req    = sel64 ? bus64.mem_req : bus32.mem_req;
    assign cur_done   = sel64 ? done64 : done32;
    assign cur_mis    = sel64 ? mis64 : mis32;
    assign cur_err    = sel64 ? err64 : err32;
    assign cur_we     = sel64 ? bus64.mem_we : bus32.mem_we;
    assign cur_be     = sel64 ? bus64.mem_be : {4'h0, bus32.mem_be};
    assign cur_maddr  = sel64 ? bus64.mem_addr : bus32.mem_addr;
    assign cur_mwdata = sel64 ? bus64.mem_wdata : {32'h0, bus32.mem_wdata};
    assign cur_rdata  = sel64 ? rdata64 : {32'h0, rdata32};

    int          stall_cnt, req_cnt, done_cnt, mis_cnt, err_cnt;
    logic [7:0]  be_seen;
    logic [31:0] maddr_seen;
    logic [63:0] mwdata_seen, rdata_seen;
    logic        mwe_seen, done_after, mis_after, err_after, req_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until the stall drops (bounded), acking after 'waits' REQ cycles
    task automatic run_access(input logic use64, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [63:0] wd,
                              input int waits, input logic [63:0] rd);
        sel64 = use64; we = w; funct3 = f3; addr = a; wdata = wd;
        req_valid32 = !use64; req_valid64 = use64;
        stall_cnt = 0; req_cnt = 0; done_cnt = 0; mis_cnt = 0; err_cnt = 0;
        be_seen = 8'h00; maddr_seen = 32'h0; mwdata_seen = 64'h0; mwe_seen = 1'b0;
        rdata_seen = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (!cur_stall) break;
            stall_cnt++;
            if (cur_req) begin
                if (req_cnt == 0) begin
                    be_seen = cur_be; maddr_seen = cur_maddr;
                    mwdata_seen = cur_mwdata; mwe_seen = cur_we;
                end
                if (req_cnt == waits) begin
                    bus32.mem_ack = !use64; bus64.mem_ack = use64;
                    bus32.mem_rdata = rd[31:0]; bus64.mem_rdata = rd;
                end
                req_cnt++;
            end
            tick();
            bus32.mem_ack = 1'b0; bus64.mem_ack = 1'b0;
            if (cur_done) begin done_cnt++; rdata_seen = cur_rdata; end
            if (cur_err) begin err_cnt++; rdata_seen = cur_rdata; end
            if (cur_mis) mis_cnt++;
        end
        req_valid32 = 1'b0; req_valid64 = 1'b0;
        tick();
        done_after = cur_done; mis_after = cur_mis; err_after = cur_err; req_after = cur_req;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel64 = 1'b0; req_valid32 = 1'b0; req_valid64 = 1'b0;
        we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 64'h0;
        bus32.mem_ack = 1'b0; bus32.mem_rdata = 32'h0;
        bus64.mem_ack = 1'b0; bus64.mem_rdata = 64'h0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checks++; if (bus32.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus32.mem_req); end
        checks++; if (bus32.mem_be !== 4'h0) begin errors++; $display("FAIL rst_be got %h exp 0", bus32.mem_be); end
        checks++; if (bus32.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus32.mem_addr); end
        checks++; if (bus32.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus32.mem_wdata); end
        checks++; if (rdata32 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata32); end
        checks++; if ({done32, mis32, err32, stall32} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {done32, mis32, err32, stall32}); end
        checks++; if ({bus64.mem_req, done64, stall64} !== 3'b000) begin errors++; $display("FAIL rst_64 got %b exp 000", {bus64.mem_req, done64, stall64}); end
        bus32.mem_ack = 1'b1;
        tick();
        bus32.mem_ack = 1'b0;
        checks++; if ({done32, bus32.mem_req} !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored got %b exp 00", {done32, bus32.mem_req}); end
    endtask

    task automatic test_lb_wait();
        run_access(1'b0, 1'b0, LSU_B, 32'h1003, 64'h0, 2, 64'h80FF_0000);
        checks++; if (be_seen !== 8'h08) begin errors++; $display("FAIL lb_be got %h exp 08", be_seen); end
        checks++; if (maddr_seen !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h exp 1000", maddr_seen); end
        checks++; if (mwe_seen !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", mwe_seen); end
        checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL lb_stall got %0d exp 4", stall_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL lb_done got %0d exp 1", done_cnt); end
        checks++; if (rdata_seen !== 64'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rdata_seen); end
        checks++; if ({done_after, req_after} !== 2'b00) begin errors++; $display("FAIL lb_after got %b exp 00", {done_after, req_after}); end
    endtask

    task automatic test_sh_store();
        run_access(1'b0, 1'b1, LSU_H, 32'h2002, 64'h1234_ABCD, 0, 64'h5555_5555);
        checks++; if (be_seen !== 8'h0C) begin errors++; $display("FAIL sh_be got %h exp 0c", be_seen); end
        checks++; if (mwdata_seen !== 64'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", mwdata_seen); end
        checks++; if ({mwe_seen, maddr_seen} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL sh_we_addr got %b/%h exp 1/2000", mwe_seen, maddr_seen); end
        checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL sh_stall got %0d exp 2", stall_cnt); end
        checks++; if ({done_cnt, done_after} !== {32'd1, 1'b0}) begin errors++; $display("FAIL sh_done_pulse got %0d/%b exp 1/0", done_cnt, done_after); end
        checks++; if (rdata_seen !== 64'h0) begin errors++; $display("FAIL sh_rdata got %h exp 0", rdata_seen); end
        run_access(1'b0, 1'b1, LSU_B, 32'h5001, 64'hA5, 0, 64'h0);
        checks++; if ({be_seen, mwdata_seen[31:0]} !== {8'h02, 32'hA5A5_A5A5}) begin errors++; $display("FAIL sb_be_wdata got %h/%h exp 02/a5a5a5a5", be_seen, mwdata_seen); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 1'b0, LSU_W, 32'h3001, 64'h0, 0, 64'h1234_5678);
        checks++; if (mis_cnt !== 1) begin errors++; $display("FAIL lw_mis_pulse got %0d exp 1", mis_cnt); end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL lw_mis_noreq got %0d exp 0", req_cnt); end
        checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lw_mis_stall got %0d exp 1", stall_cnt); end
        checks++; if ({done_cnt, mis_after} !== {32'd0, 1'b0}) begin errors++; $display("FAIL lw_mis_after got %0d/%b exp 0/0", done_cnt, mis_after); end
        run_access(1'b0, 1'b0, LSU_D, 32'h0, 64'h0, 0, 64'h0);
        checks++; if ({mis_cnt, req_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL ld_on32 got %0d/%0d exp 1/0", mis_cnt, req_cnt); end
        run_access(1'b0, 1'b0, LSU_H, 32'h3003, 64'h0, 0, 64'h0);
        checks++; if (mis_cnt !== 1) begin errors++; $display("FAIL lh_mis got %0d exp 1", mis_cnt); end
    endtask

    task automatic test_load_ext();
        run_access(1'b0, 1'b0, LSU_H, 32'h4002, 64'h0, 0, 64'h8001_1234);
        checks++; if (rdata_seen !== 64'hFFFF_8001) begin errors++; $display("FAIL lh_ext got %h exp ffff8001", rdata_seen); end
        run_access(1'b0, 1'b0, LSU_HU, 32'h4002, 64'h0, 0, 64'h8001_1234);
        checks++; if (rdata_seen !== 64'h0000_8001) begin errors++; $display("FAIL lhu_ext got %h exp 00008001", rdata_seen); end
        run_access(1'b0, 1'b0, LSU_BU, 32'h4001, 64'h0, 0, 64'h0000_F500);
        checks++; if (rdata_seen !== 64'h0000_00F5) begin errors++; $display("FAIL lbu_ext got %h exp 000000f5", rdata_seen); end
        run_access(1'b0, 1'b0, LSU_W, 32'h4000, 64'h0, 1, 64'hDEAD_BEEF);
        checks++; if ({be_seen, rdata_seen} !== {8'h0F, 64'hDEAD_BEEF}) begin errors++; $display("FAIL lw_load got %h/%h exp 0f/deadbeef", be_seen, rdata_seen); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 1'b0, LSU_BU, 32'h0, 64'h0, -1, 64'h0);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_pulse got %0d exp 1", err_cnt); end
        checks++; if (req_cnt !== 16) begin errors++; $display("FAIL to_req_cycles got %0d exp 16", req_cnt); end
        checks++; if (stall_cnt !== 17) begin errors++; $display("FAIL to_stall got %0d exp 17", stall_cnt); end
        checks++; if (rdata_seen !== 64'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", rdata_seen); end
        checks++; if ({done_cnt, err_after, req_after} !== {32'd0, 2'b00}) begin errors++; $display("FAIL to_after got %0d/%b/%b exp 0/0/0", done_cnt, err_after, req_after); end
    endtask

    task automatic test_reset_mid();
        sel64 = 1'b0; we = 1'b0; funct3 = LSU_W; addr = 32'h6000; req_valid32 = 1'b1;
        tick();
        checks++; if (bus32.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req_up got %b exp 1", bus32.mem_req); end
        tick();
        rst = 1'b1; req_valid32 = 1'b0;
        tick();
        checks++; if ({bus32.mem_req, bus32.mem_be} !== 5'b0_0000) begin errors++; $display("FAIL rm_req_drop got %b/%h exp 0/0", bus32.mem_req, bus32.mem_be); end
        rst = 1'b0; bus32.mem_ack = 1'b1;
        tick();
        bus32.mem_ack = 1'b0;
        checks++; if ({done32, bus32.mem_req} !== 2'b00) begin errors++; $display("FAIL rm_idle got %b exp 00", {done32, bus32.mem_req}); end
        run_access(1'b0, 1'b1, LSU_W, 32'h7004, 64'hCAFE_F00D, 1, 64'h0);
        checks++; if ({be_seen, mwdata_seen[31:0], maddr_seen} !== {8'h0F, 32'hCAFE_F00D, 32'h7004}) begin errors++; $display("FAIL rm_sw_bus got %h/%h/%h exp 0f/cafef00d/7004", be_seen, mwdata_seen, maddr_seen); end
        checks++; if ({done_cnt, stall_cnt} !== {32'd1, 32'd3}) begin errors++; $display("FAIL rm_sw_done got %0d/%0d exp 1/3", done_cnt, stall_cnt); end
    endtask

    task automatic test_dw64();
        run_access(1'b1, 1'b0, LSU_D, 32'h8, 64'h0, 0, 64'h1122_3344_5566_7788);
        checks++; if ({be_seen, maddr_seen} !== {8'hFF, 32'h8}) begin errors++; $display("FAIL ld_be_addr got %h/%h exp ff/8", be_seen, maddr_seen); end
        checks++; if (rdata_seen !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_rdata got %h exp 1122334455667788", rdata_seen); end
        run_access(1'b1, 1'b0, LSU_WU, 32'hC, 64'h0, 0, 64'h8000_0001_DEAD_BEEF);
        checks++; if ({be_seen, maddr_seen} !== {8'hF0, 32'h8}) begin errors++; $display("FAIL lwu_be_addr got %h/%h exp f0/8", be_seen, maddr_seen); end
        checks++; if (rdata_seen !== 64'h0000_0000_8000_0001) begin errors++; $display("FAIL lwu_rdata got %h exp 0000000080000001", rdata_seen); end
        run_access(1'b1, 1'b0, LSU_W, 32'hC, 64'h0, 0, 64'h8000_0001_DEAD_BEEF);
        checks++; if (rdata_seen !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL lw64_rdata got %h exp ffffffff80000001", rdata_seen); end
        run_access(1'b1, 1'b1, LSU_W, 32'h4, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
        checks++; if ({be_seen, mwdata_seen} !== {8'hF0, 64'h89AB_CDEF_89AB_CDEF}) begin errors++; $display("FAIL sw64 got %h/%h exp f0/89abcdef89abcdef", be_seen, mwdata_seen); end
        run_access(1'b1, 1'b1, LSU_B, 32'h7, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
        checks++; if ({be_seen, mwdata_seen} !== {8'h80, 64'hEFEF_EFEF_EFEF_EFEF}) begin errors++; $display("FAIL sb64 got %h/%h exp 80/efefefefefefefef", be_seen, mwdata_seen); end
        run_access(1'b1, 1'b0, LSU_D, 32'h4, 64'h0, 0, 64'h0);
        checks++; if ({mis_cnt, req_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL ld64_mis got %0d/%0d exp 1/0", mis_cnt, req_cnt); end
    endtask

    initial begin
        test_reset();
        test_lb_wait();
        test_sh_store();
        test_misaligned();
        test_load_ext();
        test_timeout();
        test_reset_mid();
        test_dw64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
